// File: rtl/display_scan_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
// No ports: imported by display_scan_if, scan_timer and display_scan.
package display_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SLOT_W     = 2;
    localparam int unsigned BCD_W      = 4;

    localparam logic [BCD_W-1:0]      DIG_BLANK = 4'hF;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_state_t;

    // Everything that is sampled together once per frame
    typedef struct packed {
        logic [NUM_DIGITS*BCD_W-1:0] digits;
        logic [NUM_DIGITS-1:0]       blank_mask;
        logic [NUM_DIGITS-1:0]       blink_mask;
    } frame_cfg_t;

    // Active-low anode pattern selecting a single slot
    function automatic logic [NUM_DIGITS-1:0] an_for_slot(input slot_t s);
        return ~(NUM_DIGITS'(1) << s);
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Display bus: digit/mask inputs toward the scanner and decoded scan outputs back.
//   digits[15:0]    packed BCD, [3:0]=digit0 (rightmost)
//   blank_mask[3:0] per-digit force-dark
//   blink_mask[3:0] per-digit blink enable
//   dig[3:0]        BCD code to segment decoder, 4'hF = blank
//   an[3:0]         active-low anode enables
//   frame_start     one-cycle pulse at the start of each frame
// master = producer of digits (driver side), slave = display_scan.
interface display_scan_if;
    import display_scan_pkg::*;

    logic [NUM_DIGITS*BCD_W-1:0] digits;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic [NUM_DIGITS-1:0]       blink_mask;
    logic [BCD_W-1:0]            dig;
    logic [NUM_DIGITS-1:0]       an;
    logic                        frame_start;

    modport master (
        output digits, blank_mask, blink_mask,
        input  dig, an, frame_start
    );

    modport slave (
        input  digits, blank_mask, blink_mask,
        output dig, an, frame_start
    );

endinterface

// File: rtl/display_scan_scan_timer.sv
// Scan timebase: tick counts 0..REFRESH_DIV-1 inside a slot, slot cycles 0..3.
//   clk, rst    clock, async active-high reset
//   slot        current digit slot
//   tick        cycle index within the slot
//   slot_start  high while tick==0
//   frame_wrap  high on the last tick of slot 3 (frame ends after this cycle)
module scan_timer
    import display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    localparam int unsigned TICK_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output slot_t             slot,
    output logic [TICK_W-1:0] tick,
    output logic              slot_start,
    output logic              frame_wrap
);

    localparam slot_t SLOT_LAST = slot_t'(NUM_DIGITS - 1);

    logic last_c;

    assign last_c = (tick == TICK_W'(REFRESH_DIV - 1));

    // slot_start/frame_wrap are registered one cycle ahead so they align with tick/slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick       <= '0;
            slot       <= '0;
            slot_start <= 1'b1;
            frame_wrap <= 1'b0;
        end else begin
            slot_start <= last_c;
            frame_wrap <= (slot == SLOT_LAST) && (tick == TICK_W'(REFRESH_DIV - 2));
            if (last_c) begin
                tick <= '0;
                slot <= slot + slot_t'(1);
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexes four BCD digits onto a common-anode 7-segment display with
// per-frame latching, blanking, blinking and a leading dead time in each slot.
//   clk, rst  clock, async active-high reset
//   bus       display_scan_if.slave: digits/blank_mask/blink_mask in, dig/an/frame_start out
module display_scan
    import display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);

    localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be below REFRESH_DIV");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    slot_t              slot;
    logic [TICK_W-1:0]  tick;
    logic               slot_start;
    logic               frame_wrap;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .slot       (slot),
        .tick       (tick),
        .slot_start (slot_start),
        .frame_wrap (frame_wrap)
    );

    frame_cfg_t shadow;
    frame_cfg_t live_c;
    frame_cfg_t eff_c;
    logic       frame_latch_c;

    assign live_c        = '{digits: bus.digits, blank_mask: bus.blank_mask, blink_mask: bus.blink_mask};
    assign frame_latch_c = slot_start && (slot == '0);
    // On the latch cycle use live inputs so slot 0 tick 0 already shows the new frame
    assign eff_c         = frame_latch_c ? live_c : shadow;

    // Frame shadow register: inputs only become visible at frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (frame_latch_c) begin
            shadow <= live_c;
        end
    end

    blink_state_t       blink_state, blink_state_n;
    logic [FCNT_W-1:0]  blink_cnt, blink_cnt_n;

    // Blink phase state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_state <= PHASE_ON;
            blink_cnt   <= '0;
        end else begin
            blink_state <= blink_state_n;
            blink_cnt   <= blink_cnt_n;
        end
    end

    // Blink phase next state: toggle every BLINK_FRAMES frame wraps
    always_comb begin
        blink_state_n = blink_state;
        blink_cnt_n   = blink_cnt;
        if (frame_wrap) begin
            if (blink_cnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_n   = '0;
                blink_state_n = (blink_state == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                blink_cnt_n = blink_cnt + FCNT_W'(1);
            end
        end
    end

    logic             lit_c;
    logic [BCD_W-1:0] digit_c;

    // tick+1 > BLANK_CYCLES avoids a constant compare when BLANK_CYCLES is 0
    assign lit_c   = ((32'(tick) + 32'd1) > BLANK_CYCLES)
                   && !eff_c.blank_mask[slot]
                   && !(eff_c.blink_mask[slot] && (blink_state == PHASE_OFF));
    assign digit_c = eff_c.digits[{slot, 2'b00} +: BCD_W];

    logic [NUM_DIGITS-1:0] an_q;
    logic [BCD_W-1:0]      dig_q;
    logic                  frame_start_q;

    // Registered output stage: one anode at most, blank code whenever dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q          <= AN_OFF;
            dig_q         <= DIG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            an_q          <= lit_c ? an_for_slot(slot) : AN_OFF;
            dig_q         <= lit_c ? digit_c : DIG_BLANK;
            frame_start_q <= frame_latch_c;
        end
    end

    assign bus.an          = an_q;
    assign bus.dig         = dig_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: two instances (dead time 2 and 0) share
// stimulus; a frame-level arithmetic model predicts an/dig/frame_start each cycle.
module tb_display_scan;
    import display_scan_pkg::*;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;

    int n_asserts = 0;
    int n_fail    = 0;
    int n         = 0;

    logic [15:0] sh_digits;
    logic [3:0]  sh_blank;
    logic [3:0]  sh_blink;
    logic [3:0]  exp_an, exp_dig, exp_an0, exp_dig0;
    logic        exp_fs;
    logic [3:0]  prev_an;

    display_scan_if bus ();
    display_scan_if bus0 ();

    assign bus.digits      = digits;
    assign bus.blank_mask  = blank_mask;
    assign bus.blink_mask  = blink_mask;
    assign bus0.digits     = digits;
    assign bus0.blank_mask = blank_mask;
    assign bus0.blink_mask = blink_mask;

    display_scan #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    display_scan #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (0),
        .BLINK_FRAMES (BF)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    always #5 clk = ~clk;

    // Expected display for scan position cyc (cycles since reset release)
    function automatic void model(input int cyc, input int blank,
                                  output logic [3:0] an, output logic [3:0] dig);
        int  slot     = (cyc / RD) % 4;
        int  tick     = cyc % RD;
        int  frame    = cyc / FRAME;
        bit  phase_on = ((frame / BF) % 2) == 0;
        bit  lit      = (tick >= blank) && !sh_blank[slot] && !(sh_blink[slot] && !phase_on);
        an  = 4'hF;
        dig = 4'hF;
        if (lit) begin
            an[slot] = 1'b0;
            dig      = sh_digits[slot*4 +: 4];
        end
    endfunction

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, n);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, n);
        end
    endtask

    // One clock: update model at posedge, compare both DUTs at negedge
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            n        = 0;
            exp_an   = 4'hF;
            exp_dig  = 4'hF;
            exp_an0  = 4'hF;
            exp_dig0 = 4'hF;
            exp_fs   = 1'b0;
        end else begin
            if (n % FRAME == 0) begin
                sh_digits = digits;
                sh_blank  = blank_mask;
                sh_blink  = blink_mask;
            end
            model(n, BC, exp_an, exp_dig);
            model(n, 0, exp_an0, exp_dig0);
            exp_fs = (n % FRAME == 0);
            n++;
        end
        @(negedge clk);
        check4("an", bus.an, exp_an);
        check4("dig", bus.dig, exp_dig);
        check1("frame_start", bus.frame_start, exp_fs);
        check4("an_nodead", bus0.an, exp_an0);
        check4("dig_nodead", bus0.dig, exp_dig0);
        check1("frame_start_nodead", bus0.frame_start, exp_fs);
        check1("onehot", $countones(~bus.an) <= 1, 1'b1);
        check1("onehot_nodead", $countones(~bus0.an) <= 1, 1'b1);
        check1("deadtime", (prev_an == 4'hF) || (bus.an == 4'hF) || (bus.an == prev_an), 1'b1);
        prev_an = bus.an;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    // Assert reset at a negedge and confirm outputs go dark without a clock
    task automatic reset_now();
        rst = 1'b1;
        #1;
        check4("rst_an", bus.an, 4'hF);
        check4("rst_dig", bus.dig, 4'hF);
        check1("rst_fs", bus.frame_start, 1'b0);
        check4("rst_an_nodead", bus0.an, 4'hF);
        prev_an = 4'hF;
        run(2);
    endtask

    initial begin
        digits     = 16'h1234;
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        prev_an    = 4'hF;
        rst        = 1'b0;
        #1;
        @(negedge clk);
        reset_now();

        // Basic scan 4,3,2,1 for two frames
        rst = 1'b0;
        run(2 * FRAME);

        // New digits arrive in slot 2 tick 3: invisible until next frame
        run(2 * RD + 3);
        digits = 16'h5678;
        run(RD - 3 + RD + FRAME);

        // Blank digit 2
        blank_mask = 4'b0100;
        run(2 * FRAME);

        // Blink digit 0 over six frames, plus blank+blink on the same digit
        blank_mask = 4'b0000;
        blink_mask = 4'b0001;
        run(6 * FRAME);
        blank_mask = 4'b0010;
        blink_mask = 4'b0011;
        run(4 * FRAME);

        // Reset in slot 2 tick 5 with everything lit
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        digits     = 16'h9AF0;
        while ((n % FRAME) != (2 * RD + 5)) cycle();
        reset_now();
        rst = 1'b0;
        run(FRAME + 8);

        // Randomized masks and digits changed at arbitrary points
        for (int k = 0; k < 24; k++) begin
            digits     = 16'($urandom);
            blank_mask = 4'($urandom_range(0, 15));
            blink_mask = 4'($urandom_range(0, 15));
            run(int'($urandom_range(1, 48)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
